// File: rtl/jtag_tap_ctrl_if.sv
// Pad-side and test-interface-side signals of the JTAG TAP controller.
// master = TAP controller, slave = the pads / test interface that talk to it.
interface jtag_tap_ctrl_if;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic test_logic_reset_o;
  logic capture_dr_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic extest_select_o;
  logic sample_preload_select_o;
  logic mbist_select_o;
  logic debug_select_o;
  logic bs_chain_tdo_i;
  logic debug_tdo_i;
  logic mbist_tdo_i;

  modport master (
    input  tms_i, tdi_i, bs_chain_tdo_i, debug_tdo_i, mbist_tdo_i,
    output tdo_o, tdo_oe_o, test_logic_reset_o,
    output capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
    output extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );

  modport slave (
    output tms_i, tdi_i, bs_chain_tdo_i, debug_tdo_i, mbist_tdo_i,
    input  tdo_o, tdo_oe_o, test_logic_reset_o,
    input  capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
    input  extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: one-hot TAP FSM, IR + decode, BYPASS/IDCODE registers, TDO mux.
// Define JTAG_IDCODE_EN to include the IDCODE instruction and its 32-bit register.
module jtag_tap_ctrl #(
  parameter int unsigned IR_LEN = 4,
`ifdef JTAG_IDCODE_EN
  parameter logic [31:0] IDCODE_VAL = 32'h1180_0F01,
`endif
  parameter logic [IR_LEN-1:0] OP_EXTEST = IR_LEN'(4'b0000),
  parameter logic [IR_LEN-1:0] OP_SAMPLE = IR_LEN'(4'b0001),
  parameter logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(4'b0010),
  parameter logic [IR_LEN-1:0] OP_DEBUG  = IR_LEN'(4'b1000),
  parameter logic [IR_LEN-1:0] OP_MBIST  = IR_LEN'(4'b1001)
) (
  input  logic            tck_i,
  input  logic            trst_i,
  jtag_tap_ctrl_if.master tap
);

  localparam int S_TLR    = 0;
  localparam int S_RTI    = 1;
  localparam int S_SELDR  = 2;
  localparam int S_CAPDR  = 3;
  localparam int S_SHDR   = 4;
  localparam int S_EX1DR  = 5;
  localparam int S_PDR    = 6;
  localparam int S_EX2DR  = 7;
  localparam int S_UPDDR  = 8;
  localparam int S_SELIR  = 9;
  localparam int S_CAPIR  = 10;
  localparam int S_SHIR   = 11;
  localparam int S_EX1IR  = 12;
  localparam int S_PIR    = 13;
  localparam int S_EX2IR  = 14;
  localparam int S_UPDIR  = 15;

`ifdef JTAG_IDCODE_EN
  localparam bit                IDCODE_EN = 1'b1;
  localparam logic [IR_LEN-1:0] IR_RESET  = OP_IDCODE;
`else
  localparam bit                IDCODE_EN = 1'b0;
  localparam logic [IR_LEN-1:0] IR_RESET  = '1;
`endif

  // One-hot encoding so every state decode below is a single flop output.
  typedef enum logic [15:0] {
    TLR      = 16'h0001,
    RTI      = 16'h0002,
    SEL_DR   = 16'h0004,
    CAP_DR   = 16'h0008,
    SH_DR    = 16'h0010,
    EX1_DR   = 16'h0020,
    PAUSE_DR = 16'h0040,
    EX2_DR   = 16'h0080,
    UPD_DR   = 16'h0100,
    SEL_IR   = 16'h0200,
    CAP_IR   = 16'h0400,
    SH_IR    = 16'h0800,
    EX1_IR   = 16'h1000,
    PAUSE_IR = 16'h2000,
    EX2_IR   = 16'h4000,
    UPD_IR   = 16'h8000
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d;
  logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
  logic              bypass_q, bypass_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;
  logic              idcode_tdo;

  logic ins_extest, ins_sample, ins_debug, ins_mbist, ins_idcode, ins_bypass;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tap.tms_i ? TLR    : RTI;
      RTI:      state_d = tap.tms_i ? SEL_DR : RTI;
      SEL_DR:   state_d = tap.tms_i ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tap.tms_i ? EX1_DR : SH_DR;
      SH_DR:    state_d = tap.tms_i ? EX1_DR : SH_DR;
      EX1_DR:   state_d = tap.tms_i ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = tap.tms_i ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = tap.tms_i ? UPD_DR : SH_DR;
      UPD_DR:   state_d = tap.tms_i ? SEL_DR : RTI;
      SEL_IR:   state_d = tap.tms_i ? TLR    : CAP_IR;
      CAP_IR:   state_d = tap.tms_i ? EX1_IR : SH_IR;
      SH_IR:    state_d = tap.tms_i ? EX1_IR : SH_IR;
      EX1_IR:   state_d = tap.tms_i ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = tap.tms_i ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = tap.tms_i ? UPD_IR : SH_IR;
      UPD_IR:   state_d = tap.tms_i ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Undefined opcodes (and IDCODE when the register is absent) fall through to BYPASS.
  always_comb begin
    ins_extest = (ir_q == OP_EXTEST);
    ins_sample = (ir_q == OP_SAMPLE);
    ins_debug  = (ir_q == OP_DEBUG);
    ins_mbist  = (ir_q == OP_MBIST);
    ins_idcode = IDCODE_EN && (ir_q == OP_IDCODE);
    ins_bypass = !(ins_extest || ins_sample || ins_debug || ins_mbist || ins_idcode);
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    tdo_d      = 1'b0;
    tdo_oe_d   = state_q[S_SHIR] | state_q[S_SHDR];

    if (state_q[S_CAPIR]) begin
      ir_shift_d = IR_LEN'(2'b01);
    end else if (state_q[S_SHIR]) begin
      ir_shift_d = {tap.tdi_i, ir_shift_q[IR_LEN-1:1]};
    end

    if (state_q[S_TLR]) begin
      ir_d = IR_RESET;
    end else if (state_q[S_UPDIR]) begin
      ir_d = ir_shift_q;
    end

    if (ins_bypass && state_q[S_CAPDR]) begin
      bypass_d = 1'b0;
    end else if (ins_bypass && state_q[S_SHDR]) begin
      bypass_d = tap.tdi_i;
    end

    if (state_q[S_SHIR]) begin
      tdo_d = ir_shift_q[0];
    end else if (state_q[S_SHDR]) begin
      if (ins_extest || ins_sample) begin
        tdo_d = tap.bs_chain_tdo_i;
      end else if (ins_debug) begin
        tdo_d = tap.debug_tdo_i;
      end else if (ins_mbist) begin
        tdo_d = tap.mbist_tdo_i;
      end else if (ins_idcode) begin
        tdo_d = idcode_tdo;
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_q       <= IR_RESET;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;

  always_comb begin
    idcode_d = idcode_q;
    if (ins_idcode && state_q[S_CAPDR]) begin
      idcode_d = IDCODE_VAL;
    end else if (ins_idcode && state_q[S_SHDR]) begin
      idcode_d = {tap.tdi_i, idcode_q[31:1]};
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      idcode_q <= '0;
    end else begin
      idcode_q <= idcode_d;
    end
  end

  assign idcode_tdo = idcode_q[0];
`else
  assign idcode_tdo = 1'b0;
`endif

  // TDO changes on the falling edge so the pad is stable across the next rising edge.
  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tap.tdo_o              = tdo_q;
  assign tap.tdo_oe_o           = tdo_oe_q;
  assign tap.test_logic_reset_o = state_q[S_TLR];
  assign tap.capture_dr_o       = state_q[S_CAPDR];
  assign tap.shift_dr_o         = state_q[S_SHDR];
  assign tap.pause_dr_o         = state_q[S_PDR];
  assign tap.update_dr_o        = state_q[S_UPDDR];

  assign tap.extest_select_o         = ins_extest & ~state_q[S_TLR];
  assign tap.sample_preload_select_o = ins_sample & ~state_q[S_TLR];
  assign tap.mbist_select_o          = ins_mbist  & ~state_q[S_TLR];
  assign tap.debug_select_o          = ins_debug  & ~state_q[S_TLR];

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed TMS/TDI vectors, TDO checked by a scoreboard monitor.
// Expected DR-after-reset data follows JTAG_IDCODE_EN the same way the design does.
module tb_jtag_tap_ctrl;

`ifdef JTAG_IDCODE_EN
  localparam logic [31:0] RST_DR_TDI = 32'h0000_0000;
  localparam logic [31:0] RST_DR_EXP = 32'h1180_0F01;
`else
  localparam logic [31:0] RST_DR_TDI = 32'hA5C3_0F96;
  localparam logic [31:0] RST_DR_EXP = 32'h4B86_1F2C;
`endif
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic tck = 1'b0;
  logic trst;

  jtag_tap_ctrl_if tapIf ();

  jtag_tap_ctrl dut (
    .tck_i  (tck),
    .trst_i (trst),
    .tap    (tapIf)
  );

  always #10 tck = ~tck;

  int   checkCount = 0;
  int   passCount  = 0;
  logic expTdoQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe order {capture, shift, pause, update}.
  task automatic checkStrobes(input string name, input logic [3:0] exp);
    checkOutput(name, 32'({tapIf.capture_dr_o, tapIf.shift_dr_o, tapIf.pause_dr_o, tapIf.update_dr_o}), 32'(exp));
  endtask

  // Select order {extest, sample, mbist, debug}.
  task automatic checkSelects(input string name, input logic [3:0] exp);
    checkOutput(name, 32'({tapIf.extest_select_o, tapIf.sample_preload_select_o,
                           tapIf.mbist_select_o, tapIf.debug_select_o}), 32'(exp));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tlr"}, 32'(tapIf.test_logic_reset_o), 32'd1);
    checkOutput({tag, "_tdo"}, 32'(tapIf.tdo_o), 32'd0);
    checkOutput({tag, "_tdo_oe"}, 32'(tapIf.tdo_oe_o), 32'd0);
    checkStrobes({tag, "_strobes"}, 4'b0000);
    checkSelects({tag, "_selects"}, 4'b0000);
  endtask

  // One TCK cycle: inputs change mid-low-phase, returns just after the rising edge.
  task automatic applyStimulus(input logic tms, input logic tdi);
    @(negedge tck);
    #5;
    tapIf.tms_i = tms;
    tapIf.tdi_i = tdi;
    @(posedge tck);
    #3;
  endtask

  // From RTI to UpdIR; every IR capture presents 1,0,0,0 on TDO.
  task automatic scanIr(input logic [3:0] tdiBits);
    logic [3:0] expBits;
    expBits = 4'b0001;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expTdoQ.push_back(expBits[i]);
      applyStimulus(i == 3, tdiBits[i]);
    end
    applyStimulus(1'b1, 1'b0);
  endtask

  // From RTI, full DR scan of n bits, back to RTI.
  task automatic scanDr(input int n, input logic [31:0] tdiW, input logic [31:0] expW,
                        input logic [31:0] bsW, input logic [31:0] dbgW, input logic [31:0] mbW);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tapIf.bs_chain_tdo_i = bsW[i];
      tapIf.debug_tdo_i    = dbgW[i];
      tapIf.mbist_tdo_i    = mbW[i];
      expTdoQ.push_back(expW[i]);
      applyStimulus(i == n - 1, tdiW[i]);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: TDO is stable from one falling edge to the next.
  initial begin
    logic expBit;
    forever begin
      @(negedge tck);
      #2;
      if (tapIf.tdo_oe_o === 1'b1) begin
        if (expTdoQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL tdo_unexpected: tdo_oe_o got 1 expected 0");
        end else begin
          expBit = expTdoQ.pop_front();
          checkOutput("tdo_bit", 32'(tapIf.tdo_o), 32'(expBit));
        end
      end else if (expTdoQ.size() != 0) begin
        checkCount++;
        expBit = expTdoQ.pop_front();
        $display("[TB] FAIL tdo_missing: tdo_oe_o got %0b expected 1 (bit %0b)", tapIf.tdo_oe_o, expBit);
      end else begin
        checkOutput("tdo_idle", 32'(tapIf.tdo_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    trst                 = 1'b1;
    tapIf.tms_i          = 1'b1;
    tapIf.tdi_i          = 1'b0;
    tapIf.bs_chain_tdo_i = 1'b0;
    tapIf.debug_tdo_i    = 1'b0;
    tapIf.mbist_tdo_i    = 1'b0;

    // Reset values and the DR scan that follows reset.
    #25;
    checkResetOutputs("por");
    #10;
    trst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rti_tlr_low", 32'(tapIf.test_logic_reset_o), 32'd0);
    checkSelects("rti_selects", 4'b0000);
    scanDr(32, RST_DR_TDI, RST_DR_EXP, ONES, ONES, ONES);

    // Five TMS=1 from ShIR; the pass through UpdIR loads EXTEST (0000) on the way.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expTdoQ.push_back(1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkSelects("seldr_after_upd", 4'b1000);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tms_reset_tlr", 32'(tapIf.test_logic_reset_o), 32'd1);
    checkSelects("tlr_selects", 4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkSelects("tlr_ir_reload", 4'b0000);
    scanDr(32, RST_DR_TDI, RST_DR_EXP, ONES, ONES, ONES);

    // DEBUG load: selects change only after UpdIR.
    scanIr(4'b1000);
    checkSelects("updir_old_selects", 4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkSelects("debug_select", 4'b0001);
    scanDr(4, 32'h0, 32'h6, 32'h9, 32'h6, 32'h9);

    // Undefined opcode behaves as BYPASS.
    scanIr(4'b0110);
    applyStimulus(1'b0, 1'b0);
    checkSelects("bypass_selects", 4'b0000);
    scanDr(5, 32'h0D, 32'h1A, ONES, ONES, ONES);

    // IDCODE opcode: IDCODE when present, BYPASS otherwise.
    scanIr(4'b0010);
    applyStimulus(1'b0, 1'b0);
    checkSelects("idcode_selects", 4'b0000);
    scanDr(32, RST_DR_TDI, RST_DR_EXP, ONES, ONES, ONES);

    scanIr(4'b0001);
    applyStimulus(1'b0, 1'b0);
    checkSelects("sample_select", 4'b0100);
    scanDr(4, 32'h0, 32'h3, 32'h3, 32'hC, 32'hC);

    // EXTEST with a PauseDR detour; chain bit forced to 1 outside ShDR must not reach TDO.
    scanIr(4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkSelects("extest_select", 4'b1000);
    applyStimulus(1'b1, 1'b0);
    checkStrobes("seldr_strobes", 4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("capdr_strobe", 4'b1000);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("shdr_strobe", 4'b0100);
    tapIf.bs_chain_tdo_i = 1'b1;
    expTdoQ.push_back(1'b1);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("shdr_strobe2", 4'b0100);
    tapIf.bs_chain_tdo_i = 1'b0;
    expTdoQ.push_back(1'b0);
    applyStimulus(1'b1, 1'b0);
    checkStrobes("ex1dr_strobes", 4'b0000);
    tapIf.bs_chain_tdo_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkStrobes("pausedr_strobe", 4'b0010);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("pausedr_strobe2", 4'b0010);
    applyStimulus(1'b1, 1'b0);
    checkStrobes("ex2dr_strobes", 4'b0000);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("shdr_strobe3", 4'b0100);
    expTdoQ.push_back(1'b1);
    applyStimulus(1'b1, 1'b0);
    checkStrobes("ex1dr_strobes2", 4'b0000);
    applyStimulus(1'b1, 1'b0);
    checkStrobes("upddr_strobe", 4'b0001);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("rti_strobes", 4'b0000);
    checkSelects("extest_kept", 4'b1000);

    scanIr(4'b1001);
    applyStimulus(1'b0, 1'b0);
    checkSelects("mbist_select", 4'b0010);
    scanDr(4, 32'h0, 32'hA, 32'h5, 32'h5, 32'hA);

    // Async reset two bits into an IR shift.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expTdoQ.push_back(1'b1);
    applyStimulus(1'b0, 1'b1);
    expTdoQ.push_back(1'b0);
    applyStimulus(1'b0, 1'b1);
    #2;
    trst = 1'b1;
    #1;
    checkResetOutputs("async");
    #40;
    trst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkSelects("post_abort_selects", 4'b0000);
    scanDr(32, RST_DR_TDI, RST_DR_EXP, ONES, ONES, ONES);

    applyStimulus(1'b0, 1'b0);
    checkOutput("scoreboard_drained", 32'(expTdoQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
